// File: rtl/sprite_anim_render.sv
// Sprite renderer: 3-stage ROM/palette pixel pipeline plus a frame_tick-driven
// animation FSM that selects which ROM frame is addressed.
module sprite_anim_render #(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 96,
    parameter int FRAMES     = 4,
    parameter int IDX_W      = 3,
    parameter int HOLD_TICKS = 6,
    parameter int TRANSP_IDX = 0,
    localparam int AW = $clog2(SPR_W * SPR_H * FRAMES),
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic [9:0]       draw_x,
    input  logic [9:0]       draw_y,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic             flip,
    input  logic             blank,
    input  logic             frame_tick,
    input  logic             start,
    input  logic             loop,
    output logic [AW-1:0]    rom_addr,
    input  logic [IDX_W-1:0] rom_q,
    output logic [IDX_W-1:0] pal_idx,
    input  logic [3:0]       pal_r,
    input  logic [3:0]       pal_g,
    input  logic [3:0]       pal_b,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             opaque,
    output logic [FW-1:0]    frame,
    output logic             busy,
    output logic             done
);

    localparam int TW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [10:0]      W11        = 11'(SPR_W);
    localparam logic [10:0]      H11        = 11'(SPR_H);
    localparam logic [AW-1:0]    W_AW       = AW'(SPR_W);
    localparam logic [AW-1:0]    FRAME_SZ   = AW'(SPR_W * SPR_H);
    localparam logic [IDX_W-1:0] TRANSP     = IDX_W'(TRANSP_IDX);
    localparam logic [TW-1:0]    TICK_LAST  = TW'(HOLD_TICKS - 1);
    localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [FW-1:0]  frame_q, frame_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic           done_q, done_d;

    // ---------------- animation FSM ----------------
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = PLAY;
            frame_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: frame_d = '0;
                PLAY: begin
                    if (frame_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d = '0;
                            if (frame_q == FRAME_LAST) begin
                                if (loop) begin
                                    frame_d = '0;
                                end else begin
                                    state_d = DONE;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                frame_d = frame_q + 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                DONE: frame_d = FRAME_LAST;
                default: state_d = IDLE;
            endcase
        end
    end

    assign frame = frame_q;
    assign busy  = (state_q == PLAY);
    assign done  = done_q;

    // ---------------- pixel pipeline ----------------
    logic [10:0]   lx, ly, cx;
    logic          hit;
    logic [AW-1:0] addr_d;
    logic          hit1, blank1, hit2, blank2;

    // Offsets are 11-bit two's complement; bit 10 set means left of / above the sprite.
    assign lx  = {1'b0, draw_x} - {1'b0, pos_x};
    assign ly  = {1'b0, draw_y} - {1'b0, pos_y};
    assign hit = !lx[10] && (lx < W11) && !ly[10] && (ly < H11);
    assign cx  = flip ? (W11 - 11'd1 - lx) : lx;

    always_comb begin
        addr_d = '0;
        if (hit) begin
            addr_d = AW'(frame_q) * FRAME_SZ + AW'(ly) * W_AW + AW'(cx);
        end
    end

    assign pal_idx = rom_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            hit1     <= 1'b0;
            blank1   <= 1'b0;
            hit2     <= 1'b0;
            blank2   <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            opaque   <= 1'b0;
        end else begin
            rom_addr <= addr_d;
            hit1     <= hit;
            blank1   <= blank;
            hit2     <= hit1;
            blank2   <= blank1;
            if (blank2 && hit2 && (rom_q != TRANSP)) begin
                red    <= pal_r;
                green  <= pal_g;
                blue   <= pal_b;
                opaque <= 1'b1;
            end else begin
                red    <= '0;
                green  <= '0;
                blue   <= '0;
                opaque <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_anim_render.sv
// Directed bench for sprite_anim_render with default parameters and a
// one-cycle-latency ROM model returning a bench-chosen index.
module tb_sprite_anim_render;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  draw_x, draw_y, pos_x, pos_y;
    logic        flip, blank, frame_tick, start, loop;
    logic [14:0] rom_addr;
    logic [2:0]  rom_q, pal_idx, rom_val;
    logic [3:0]  pal_r, pal_g, pal_b, red, green, blue;
    logic        opaque, busy, done;
    logic [1:0]  frame;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    sprite_anim_render dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .flip       (flip),
        .blank      (blank),
        .frame_tick (frame_tick),
        .start      (start),
        .loop       (loop),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pal_idx    (pal_idx),
        .pal_r      (pal_r),
        .pal_g      (pal_g),
        .pal_b      (pal_b),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .opaque     (opaque),
        .frame      (frame),
        .busy       (busy),
        .done       (done)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom_val;

    always @(negedge vga_clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // Present a pixel, check the stage-1 address, then the colour three edges later.
    task automatic probe(input string tag, input int x, input int y, input logic fl,
                         input logic bl, input int exp_addr, input logic exp_op,
                         input logic [11:0] exp_rgb);
        draw_x = 10'(x);
        draw_y = 10'(y);
        flip   = fl;
        blank  = bl;
        step();
        check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        step();
        step();
        check({tag, ".opaque"}, 32'(opaque), 32'(exp_op));
        check({tag, ".rgb"}, 32'({red, green, blue}), 32'(exp_rgb));
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        draw_x = 10'd0; draw_y = 10'd0;
        pos_x = 10'd100; pos_y = 10'd50;
        flip = 1'b0; blank = 1'b1;
        frame_tick = 1'b0; start = 1'b0; loop = 1'b1;
        rom_val = 3'd5;
        pal_r = 4'hF; pal_g = 4'hA; pal_b = 4'h3;

        #12;
        check("rst.addr",   32'(rom_addr), 32'd0);
        check("rst.rgb",    32'({red, green, blue}), 32'd0);
        check("rst.opaque", 32'(opaque), 32'd0);
        check("rst.frame",  32'(frame), 32'd0);
        check("rst.busy",   32'(busy), 32'd0);
        check("rst.done",   32'(done), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Latency: miss at (0,0) fills the pipe, then origin hit appears on the 3rd edge.
        probe("flush", 0, 0, 1'b0, 1'b1, 0, 1'b0, 12'h000);
        draw_x = 10'd100; draw_y = 10'd50;
        step();
        check("lat.addr", 32'(rom_addr), 32'd0);
        check("lat.e1",   32'(opaque), 32'd0);
        step();
        check("lat.e2",   32'(opaque), 32'd0);
        check("lat.pal_idx", 32'(pal_idx), 32'd5);
        step();
        check("lat.e3",   32'(opaque), 32'd1);
        check("lat.rgb",  32'({red, green, blue}), 32'hFA3);

        probe("flip1",   100,  51, 1'b1, 1'b1,  127, 1'b1, 12'hFA3);
        probe("flip0",   100,  51, 1'b0, 1'b1,   64, 1'b1, 12'hFA3);
        probe("left",     99,  50, 1'b0, 1'b1,    0, 1'b0, 12'h000);
        probe("right",   164,  50, 1'b0, 1'b1,    0, 1'b0, 12'h000);
        probe("lastcol", 163,  50, 1'b0, 1'b1,   63, 1'b1, 12'hFA3);
        probe("lastrow", 100, 145, 1'b0, 1'b1, 6080, 1'b1, 12'hFA3);
        probe("below",   100, 146, 1'b0, 1'b1,    0, 1'b0, 12'h000);
        probe("above",   100,  49, 1'b0, 1'b1,    0, 1'b0, 12'h000);
        rom_val = 3'd0;
        probe("transp",  101,  52, 1'b0, 1'b1,  129, 1'b0, 12'h000);
        rom_val = 3'd5;
        probe("blank0",  101,  52, 1'b0, 1'b0,  129, 1'b0, 12'h000);

        // Looping animation.
        loop = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("loop.busy0",  32'(busy), 32'd1);
        check("loop.frame0", 32'(frame), 32'd0);
        for (int k = 1; k <= 24; k++) begin
            pulse_tick();
            check($sformatf("loop.frame.t%0d", k), 32'(frame), 32'((k / 6) % 4));
            check($sformatf("loop.busy.t%0d", k), 32'(busy), 32'd1);
            if (k == 6) probe("frame1.origin", 100, 50, 1'b0, 1'b1, 6144, 1'b1, 12'hFA3);
            step();
        end
        check("loop.nodone", 32'(done_cnt), 32'd0);

        // One-shot animation.
        loop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            pulse_tick();
            if (k < 24) begin
                check($sformatf("shot.frame.t%0d", k), 32'(frame), 32'((k / 6) % 4));
            end else begin
                check("shot.end.frame", 32'(frame), 32'd3);
                check("shot.end.done",  32'(done), 32'd1);
                check("shot.end.busy",  32'(busy), 32'd0);
            end
            step();
        end
        check("shot.done.low", 32'(done), 32'd0);
        check("shot.done.cnt", 32'(done_cnt), 32'd1);
        for (int k = 0; k < 8; k++) begin
            pulse_tick();
        end
        check("done.hold.frame", 32'(frame), 32'd3);
        check("done.hold.busy",  32'(busy), 32'd0);
        check("done.hold.cnt",   32'(done_cnt), 32'd1);

        // Start beats a simultaneous tick; counter restarts at zero.
        start = 1'b1;
        frame_tick = 1'b1;
        step();
        start = 1'b0;
        frame_tick = 1'b0;
        check("restart.frame", 32'(frame), 32'd0);
        check("restart.busy",  32'(busy), 32'd1);
        for (int k = 0; k < 5; k++) pulse_tick();
        check("restart.t5", 32'(frame), 32'd0);
        pulse_tick();
        check("restart.t6", 32'(frame), 32'd1);

        // Reset mid-animation at frame 2.
        loop = 1'b1;
        for (int k = 0; k < 6; k++) pulse_tick();
        check("pre_rst.frame", 32'(frame), 32'd2);
        draw_x = 10'd100; draw_y = 10'd50; blank = 1'b1; flip = 1'b0;
        step(); step(); step();
        check("pre_rst.opaque", 32'(opaque), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst.frame",  32'(frame), 32'd0);
        check("mid_rst.busy",   32'(busy), 32'd0);
        check("mid_rst.opaque", 32'(opaque), 32'd0);
        check("mid_rst.rgb",    32'({red, green, blue}), 32'd0);
        check("mid_rst.addr",   32'(rom_addr), 32'd0);
        check("mid_rst.done",   32'(done), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        for (int k = 0; k < 7; k++) pulse_tick();
        check("post_rst.frame", 32'(frame), 32'd0);
        check("post_rst.busy",  32'(busy), 32'd0);
        check("post_rst.done",  32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
